// File: rtl/ahb_lite_tester_pkg.sv
// Shared encodings and the test-pattern definition for the AHB-Lite memory tester.
package ahb_lite_tester_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [2:0] HSIZE_WORD    = 3'b010;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;

  typedef enum logic [1:0] {
    MODE_ADDR = 2'd0,
    MODE_INV  = 2'd1,
    MODE_HALF = 2'd2,
    MODE_WALK = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_DELAY = 2'd0,
    ST_WRITE = 2'd1,
    ST_CHECK = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  function automatic logic [31:0] pattern(input logic [31:0] addr,
                                          input logic [4:0]  index,
                                          input mode_e       mode);
    logic [31:0] data;
    case (mode)
      MODE_ADDR: data = addr;
      MODE_INV:  data = ~addr;
      MODE_HALF: data = {addr[15:0], ~addr[15:0]};
      default:   data = 32'h1 << index;
    endcase
    return data;
  endfunction

endpackage

// File: rtl/ahb_lite_tester_pattern.sv
// Combinational pattern generator shared by the write-data and expected-read-data paths.
module ahb_lite_tester_pattern
  import ahb_lite_tester_pkg::*;
(
  input  logic [31:0] addr,
  input  logic [4:0]  index,
  input  logic [1:0]  mode,
  output logic [31:0] data
);

  assign data = pattern(addr, index, mode_e'(mode));

endmodule

// File: rtl/ahb_lite_mem_tester.sv
// AHB-Lite master that writes a pattern over a memory window, then reads it back
// PASS_CNT times, counting mismatches and error responses.
//
// state | meaning
// DELAY | start-up wait of 2^DELAY_BITS cycles
// WRITE | one pass of NONSEQ writes
// CHECK | read-back passes, CHKCOUNT counts completed ones
// DONE  | idle bus, pass/fail reported, RESTART starts a new run
module ahb_lite_mem_tester
  import ahb_lite_tester_pkg::*;
#(
  parameter int WORD_CNT   = 1024,
  parameter int PASS_CNT   = 10,
  parameter int DELAY_BITS = 18
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  output logic [31:0] HADDR,
  output logic [2:0]  HBURST,
  output logic        HSEL,
  output logic [2:0]  HSIZE,
  output logic [1:0]  HTRANS,
  output logic [31:0] HWDATA,
  output logic        HWRITE,
  input  logic [31:0] HRDATA,
  input  logic        HREADY,
  input  logic        HRESP,
  input  logic [31:0] START_ADDR,
  input  logic [1:0]  MODE,
  input  logic        RESTART,
  output logic [31:0] ERRCOUNT,
  output logic [7:0]  CHKCOUNT,
  output logic [31:0] FIRST_ERR_ADDR,
  output logic        S_WRITE,
  output logic        S_CHECK,
  output logic        S_SUCCESS,
  output logic        S_FAILED
);

  localparam logic [31:0] LAST_IDX = 32'(WORD_CNT - 1);
  localparam logic [8:0]  PASS_LIM = 9'(PASS_CNT);

  state_e state, state_nxt;

  logic [DELAY_BITS-1:0] dly_cnt;
  logic [31:0] base_addr;
  logic [1:0]  mode_q;
  logic [31:0] idx;
  logic [31:0] haddr_q;
  logic [1:0]  htrans_q;
  logic        hwrite_q;
  logic [31:0] hwdata_q;
  logic        dp_valid;
  logic [31:0] dp_addr;
  logic [4:0]  dp_idx;
  logic [31:0] errcount;
  logic [7:0]  chkcount;
  logic [31:0] first_err_addr;

  logic [31:0] start_aligned;
  logic [31:0] pat_addr;
  logic [4:0]  pat_idx;
  logic [31:0] pat_data;
  logic        active;
  logic        dp_done;
  logic        dp_err;
  logic        pass_end;
  logic [8:0]  chk_inc;
  logic        load_run;
  logic        next_pass;

  assign start_aligned = START_ADDR & 32'hFFFF_FFFC;
  assign active        = (state == ST_WRITE) || (state == ST_CHECK);
  assign dp_done       = active && HREADY && dp_valid;
  assign pass_end      = dp_done && (htrans_q == HTRANS_IDLE);
  assign chk_inc       = {1'b0, chkcount} + 9'd1;

  // Writes need the pattern of the address being issued; reads need the one being returned.
  assign pat_addr = hwrite_q ? haddr_q : dp_addr;
  assign pat_idx  = hwrite_q ? idx[4:0] : dp_idx;

  ahb_lite_tester_pattern u_pattern (
    .addr  (pat_addr),
    .index (pat_idx),
    .mode  (mode_q),
    .data  (pat_data)
  );

  assign dp_err = HRESP || (!hwrite_q && (HRDATA != pat_data));

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state <= ST_DELAY;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    load_run  = 1'b0;
    next_pass = 1'b0;
    case (state)
      ST_DELAY: begin
        if (dly_cnt == '1) begin
          state_nxt = ST_WRITE;
          load_run  = 1'b1;
        end
      end
      ST_WRITE: begin
        if (pass_end) begin
          state_nxt = ST_CHECK;
          next_pass = 1'b1;
        end
      end
      ST_CHECK: begin
        if (pass_end) begin
          if (chk_inc < PASS_LIM) begin
            next_pass = 1'b1;
          end else begin
            state_nxt = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        if (RESTART) begin
          state_nxt = ST_WRITE;
          load_run  = 1'b1;
        end
      end
      default: state_nxt = ST_DELAY;
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      dly_cnt        <= '0;
      base_addr      <= 32'd0;
      mode_q         <= 2'd0;
      idx            <= 32'd0;
      haddr_q        <= 32'd0;
      htrans_q       <= HTRANS_IDLE;
      hwrite_q       <= 1'b0;
      hwdata_q       <= 32'd0;
      dp_valid       <= 1'b0;
      dp_addr        <= 32'd0;
      dp_idx         <= 5'd0;
      errcount       <= 32'd0;
      chkcount       <= 8'd0;
      first_err_addr <= 32'd0;
    end else begin
      if (state == ST_DELAY) begin
        dly_cnt <= dly_cnt + 1'b1;
      end

      if (load_run) begin
        base_addr      <= start_aligned;
        mode_q         <= MODE;
        errcount       <= 32'd0;
        chkcount       <= 8'd0;
        first_err_addr <= 32'd0;
        haddr_q        <= start_aligned;
        htrans_q       <= HTRANS_NONSEQ;
        hwrite_q       <= 1'b1;
        idx            <= 32'd0;
        dp_valid       <= 1'b0;
      end else if (active && HREADY) begin
        // errcount of zero doubles as "no error yet this run" since it saturates
        if (dp_valid && dp_err) begin
          if (errcount != 32'hFFFF_FFFF) begin
            errcount <= errcount + 32'd1;
          end
          if (errcount == 32'd0) begin
            first_err_addr <= dp_addr;
          end
        end

        if (htrans_q == HTRANS_NONSEQ) begin
          dp_valid <= 1'b1;
          dp_addr  <= haddr_q;
          dp_idx   <= idx[4:0];
          if (hwrite_q) begin
            hwdata_q <= pat_data;
          end
          if (idx == LAST_IDX) begin
            htrans_q <= HTRANS_IDLE;
          end else begin
            idx     <= idx + 32'd1;
            haddr_q <= haddr_q + 32'd4;
          end
        end else begin
          dp_valid <= 1'b0;
          if (pass_end && (state == ST_CHECK)) begin
            chkcount <= chk_inc[7:0];
          end
          if (next_pass) begin
            haddr_q  <= base_addr;
            htrans_q <= HTRANS_NONSEQ;
            hwrite_q <= 1'b0;
            idx      <= 32'd0;
          end
        end
      end
    end
  end

  assign HADDR          = haddr_q;
  assign HTRANS         = htrans_q;
  assign HWRITE         = hwrite_q;
  assign HWDATA         = hwdata_q;
  assign HSEL           = 1'b1;
  assign HSIZE          = HSIZE_WORD;
  assign HBURST         = HBURST_SINGLE;
  assign ERRCOUNT       = errcount;
  assign CHKCOUNT       = chkcount;
  assign FIRST_ERR_ADDR = first_err_addr;
  assign S_WRITE        = (state == ST_WRITE);
  assign S_CHECK        = (state == ST_CHECK);
  assign S_SUCCESS      = (state == ST_DONE) && (errcount == 32'd0);
  assign S_FAILED       = (state == ST_DONE) && (errcount != 32'd0);

endmodule

// File: doc/ahb_lite_mem_tester.md
AHB_LITE_MEM_TESTER -- requirements
Module: ahb_lite_mem_tester

Interface
REQ-001 SHALL have parameter WORD_CNT, default 1024: 32-bit words written and read per pass, minimum 1.
REQ-002 SHALL have parameter PASS_CNT, default 10: read-check passes per run, 1..255.
REQ-003 SHALL have parameter DELAY_BITS, default 18: start-up delay of 2^DELAY_BITS HCLK cycles.
REQ-004 SHALL have port HCLK  in  1: the single clock; all logic on rising edge.
REQ-005 SHALL have port HRESETn  in  1: reset, synchronous, active-low.
REQ-006 SHALL have master outputs HADDR out 32, HBURST out 3, HSEL out 1, HSIZE out 3, HTRANS out 2, HWDATA out 32, HWRITE out 1.
REQ-007 SHALL have inputs HRDATA in 32, HREADY in 1 (slave HREADYOUT), HRESP in 1 (1 = ERROR).
REQ-008 SHALL have inputs START_ADDR in 32 (word aligned, bits[1:0] ignored), MODE in 2 (pattern select), RESTART in 1 (level).
REQ-009 SHALL have outputs ERRCOUNT out 32, CHKCOUNT out 8 (completed passes), FIRST_ERR_ADDR out 32.
REQ-010 SHALL have status outputs S_WRITE, S_CHECK, S_SUCCESS, S_FAILED, each out 1, one-hot or all zero.

Function
REQ-011 SHALL use the states DELAY, WRITE, CHECK, DONE; S_WRITE=1 in WRITE, S_CHECK=1 in CHECK; S_SUCCESS/S_FAILED only in DONE.
REQ-012 SHALL stay in DELAY 2^DELAY_BITS cycles, then latch START_ADDR and MODE and enter WRITE.
REQ-013 SHALL drive HSEL=1, HSIZE=2 (word), HBURST=0 (SINGLE) always; HTRANS=2 (NONSEQ) or 0 (IDLE) only.
REQ-014 SHALL, in WRITE/CHECK, issue WORD_CNT NONSEQ address phases at START_ADDR + 4*i, i = 0..WORD_CNT-1, advancing i only in cycles with HREADY=1; address wraps modulo 2^32.
REQ-015 SHALL hold HADDR, HTRANS, HWRITE stable while HREADY=0.
REQ-016 SHALL drive HWDATA = pattern(addr of preceding address phase) during the data phase, held while HREADY=0.
REQ-017 SHALL define pattern: MODE 0 = addr; 1 = ~addr; 2 = {addr[15:0], ~addr[15:0]}; 3 = 1 << i[4:0] (walking one).
REQ-018 SHALL, in CHECK, compare HRDATA to pattern of the data-phase address in the cycle its data phase ends (HREADY=1).
REQ-019 SHALL count one error per data phase with HRDATA mismatch or HRESP=1 (read or write), never two per phase.
REQ-020 SHALL saturate ERRCOUNT at 32'hFFFF_FFFF; SHALL load FIRST_ERR_ADDR only on the first error since run start.
REQ-021 SHALL drive HTRANS=IDLE after the last address phase of a pass and change state only once its data phase completes; max one IDLE cycle between passes with zero-wait slave.
REQ-022 SHALL go WRITE -> CHECK after the write pass; CHECK -> CHECK with CHKCOUNT+1 per pass while CHKCOUNT+1 < PASS_CNT; else CHKCOUNT+1 and -> DONE.
REQ-023 SHALL in DONE drive HTRANS=IDLE, S_SUCCESS = (ERRCOUNT==0), S_FAILED = (ERRCOUNT!=0).
REQ-024 SHALL, in DONE with RESTART=1, clear ERRCOUNT, CHKCOUNT, FIRST_ERR_ADDR, relatch START_ADDR/MODE, enter WRITE next cycle; RESTART ignored in other states.
REQ-025 SHALL drive HWRITE=1 for WRITE address phases, 0 for CHECK.

Reset
REQ-026 SHALL, on HCLK edge with HRESETn=0, enter DELAY and clear delay counter, word index, all counters and status; HADDR=0, HWDATA=0, HTRANS=IDLE, HWRITE=0.
REQ-027 SHALL treat reset mid-transfer as abort: no pending data phase compared or counted after reset.

Structure
REQ-028 SHALL place HTRANS/HSIZE/HBURST encodings, MODE encodings and the pattern function in package ahb_lite_tester_pkg.
REQ-029 SHALL instantiate one combinational sub-module ahb_lite_tester_pattern (addr, index, mode -> data), used by both write-data and expected-data paths.

Verification
REQ-030 Zero-wait memory model, WORD_CNT=16, PASS_CNT=2, MODE 0, START_ADDR 0x100 -> writes 0x100..0x13C data=addr, CHKCOUNT=2, ERRCOUNT=0, S_SUCCESS=1.
REQ-031 HREADY randomly low 0-3 cycles, MODE 3 -> HADDR/HWDATA stable during waits, word 5 holds 0x20, ERRCOUNT=0.
REQ-032 Model corrupts read of 0x108 once per pass, PASS_CNT=3 -> ERRCOUNT=3, FIRST_ERR_ADDR=0x108, S_FAILED=1.
REQ-033 HRESP=1 on one write data phase -> ERRCOUNT=1; START_ADDR 0xFFFF_FFF8, WORD_CNT=4 -> addresses wrap to 0x0, 0x4.
REQ-034 HRESETn=0 for one cycle mid-CHECK -> next cycle HTRANS=IDLE, counters 0, state DELAY; RESTART in DONE -> fresh run, ERRCOUNT=0.
